// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired multi-cycle control sequencer driving every Datapath control input
// Fetch T0-T2, decode ir, then per-opcode execute steps; outputs are a decode of state_q and ir.
module control_unit #(
  parameter int OP_W  = 5,
  parameter int ALU_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             stop,
  output logic             run,
  output logic             pc_out,
  output logic             zlo_out,
  output logic             zhi_out,
  output logic             hi_out,
  output logic             lo_out,
  output logic             mdr_out,
  output logic             c_sign_extended_out,
  output logic             ba_out,
  output logic             r_out,
  output logic             mar_enable,
  output logic             z_enable,
  output logic             pc_enable,
  output logic             mdr_enable,
  output logic             ir_enable,
  output logic             y_enable,
  output logic             lo_enable,
  output logic             hi_enable,
  output logic             r_in,
  output logic             con_enable,
  output logic             read,
  output logic             ram_write,
  output logic             pc_increment,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic [ALU_W-1:0] alu_op
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(5'b00001);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(5'b00010);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(5'b01101);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(5'b01110);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);

  state_t state_q, state_d;

  logic [OP_W-1:0]  opcode;
  logic             ir_unused;
  logic             is_ld, is_ldi, is_st, is_reg, is_imm, is_br, is_halt, is_nop;
  logic             last_step;
  logic [ALU_W-1:0] alu_sel;

  assign opcode    = ir[31 -: OP_W];
  assign ir_unused = ^ir[31-OP_W:0];

  // Opcode classes; anything unrecognised (including the nop encoding) falls through as nop.
  always_comb begin
    is_ld   = 1'b0;
    is_ldi  = 1'b0;
    is_st   = 1'b0;
    is_reg  = 1'b0;
    is_imm  = 1'b0;
    is_br   = 1'b0;
    is_halt = 1'b0;
    alu_sel = ALU_ADD;
    case (opcode)
      OP_LD:   is_ld = 1'b1;
      OP_LDI:  is_ldi = 1'b1;
      OP_ST:   is_st = 1'b1;
      OP_ADD:  is_reg = 1'b1;
      OP_SUB:  begin is_reg = 1'b1; alu_sel = ALU_SUB; end
      OP_AND:  begin is_reg = 1'b1; alu_sel = ALU_AND; end
      OP_OR:   begin is_reg = 1'b1; alu_sel = ALU_OR;  end
      OP_ADDI: is_imm = 1'b1;
      OP_ANDI: begin is_imm = 1'b1; alu_sel = ALU_AND; end
      OP_ORI:  begin is_imm = 1'b1; alu_sel = ALU_OR;  end
      OP_BR:   is_br = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  assign is_nop = ~(is_ld | is_ldi | is_st | is_reg | is_imm | is_br | is_halt);

  always_comb begin
    state_d   = state_q;
    last_step = 1'b0;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  state_d = S_T3;
      S_T3: begin
        if (is_halt)     state_d = S_HALT;
        else if (is_nop) last_step = 1'b1;
        else             state_d = S_T4;
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (is_ld | is_st | is_br) state_d = S_T6;
        else                       last_step = 1'b1;
      end
      S_T6: begin
        if (is_br) last_step = 1'b1;
        else       state_d = S_T7;
      end
      S_T7:   last_step = 1'b1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    // stop only matters at an instruction boundary
    if (last_step) state_d = stop ? S_HALT : S_T0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_RST;
    else     state_q <= state_d;
  end

  assign run       = (state_q != S_RST) && (state_q != S_HALT);
  assign zhi_out   = 1'b0;
  assign hi_out    = 1'b0;
  assign lo_out    = 1'b0;
  assign lo_enable = 1'b0;
  assign hi_enable = 1'b0;

  always_comb begin
    pc_out = 1'b0; zlo_out = 1'b0; mdr_out = 1'b0; c_sign_extended_out = 1'b0;
    ba_out = 1'b0; r_out = 1'b0; mar_enable = 1'b0; z_enable = 1'b0;
    pc_enable = 1'b0; mdr_enable = 1'b0; ir_enable = 1'b0; y_enable = 1'b0;
    r_in = 1'b0; con_enable = 1'b0; read = 1'b0; ram_write = 1'b0;
    pc_increment = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
    alu_op = ALU_ADD;
    case (state_q)
      S_T0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1; end
      S_T1: begin zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1; end
      S_T2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
      S_T3: begin
        if (is_ld | is_ldi | is_st) begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
        if (is_reg | is_imm)        begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
        if (is_br)                  begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
      end
      S_T4: begin
        if (is_ld | is_ldi | is_st) begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
        if (is_imm) begin c_sign_extended_out = 1'b1; z_enable = 1'b1; alu_op = alu_sel; end
        if (is_reg) begin grc = 1'b1; r_out = 1'b1; z_enable = 1'b1; alu_op = alu_sel; end
        if (is_br)  begin pc_out = 1'b1; y_enable = 1'b1; end
      end
      S_T5: begin
        if (is_ldi | is_reg | is_imm) begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        if (is_ld | is_st)            begin zlo_out = 1'b1; mar_enable = 1'b1; end
        if (is_br)                    begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
      end
      S_T6: begin
        if (is_ld)           begin read = 1'b1; mdr_enable = 1'b1; end
        if (is_st)           begin gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1; end
        if (is_br && con_ff) begin zlo_out = 1'b1; pc_enable = 1'b1; end
      end
      S_T7: begin
        if (is_ld) begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        if (is_st) ram_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
// Each task starts when the next falling edge shows T0 (or RST) and leaves the DUT at the same point.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr, con_ff, stop;
  logic [31:0] ir;
  logic run, pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, c_sign_extended_out, ba_out, r_out;
  logic mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable, lo_enable, hi_enable;
  logic r_in, con_enable, read, ram_write, pc_increment, gra, grb, grc;
  logic [3:0] alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit #(.OP_W(5), .ALU_W(4)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run),
    .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_out(hi_out), .lo_out(lo_out),
    .mdr_out(mdr_out), .c_sign_extended_out(c_sign_extended_out), .ba_out(ba_out), .r_out(r_out),
    .mar_enable(mar_enable), .z_enable(z_enable), .pc_enable(pc_enable), .mdr_enable(mdr_enable),
    .ir_enable(ir_enable), .y_enable(y_enable), .lo_enable(lo_enable), .hi_enable(hi_enable),
    .r_in(r_in), .con_enable(con_enable), .read(read), .ram_write(ram_write),
    .pc_increment(pc_increment), .gra(gra), .grb(grb), .grc(grc), .alu_op(alu_op)
  );

  always #5 clk = ~clk;

  localparam logic [29:0] M_GRC    = 30'(1) << 4;
  localparam logic [29:0] M_GRB    = 30'(1) << 5;
  localparam logic [29:0] M_GRA    = 30'(1) << 6;
  localparam logic [29:0] M_PCINC  = 30'(1) << 7;
  localparam logic [29:0] M_RAMW   = 30'(1) << 8;
  localparam logic [29:0] M_READ   = 30'(1) << 9;
  localparam logic [29:0] M_CONEN  = 30'(1) << 10;
  localparam logic [29:0] M_RIN    = 30'(1) << 11;
  localparam logic [29:0] M_YEN    = 30'(1) << 14;
  localparam logic [29:0] M_IREN   = 30'(1) << 15;
  localparam logic [29:0] M_MDREN  = 30'(1) << 16;
  localparam logic [29:0] M_PCEN   = 30'(1) << 17;
  localparam logic [29:0] M_ZEN    = 30'(1) << 18;
  localparam logic [29:0] M_MAREN  = 30'(1) << 19;
  localparam logic [29:0] M_ROUT   = 30'(1) << 20;
  localparam logic [29:0] M_BAOUT  = 30'(1) << 21;
  localparam logic [29:0] M_CSE    = 30'(1) << 22;
  localparam logic [29:0] M_MDROUT = 30'(1) << 23;
  localparam logic [29:0] M_ZLOOUT = 30'(1) << 27;
  localparam logic [29:0] M_PCOUT  = 30'(1) << 28;
  localparam logic [29:0] M_RUN    = 30'(1) << 29;

  localparam logic [29:0] F0 = M_RUN | M_PCOUT | M_MAREN | M_PCINC | M_ZEN;
  localparam logic [29:0] F1 = M_RUN | M_ZLOOUT | M_PCEN | M_READ | M_MDREN;
  localparam logic [29:0] F2 = M_RUN | M_MDROUT | M_IREN;
  localparam logic [29:0] WB = M_RUN | M_ZLOOUT | M_GRA | M_RIN;

  function automatic logic [29:0] outs();
    return {run, pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, c_sign_extended_out, ba_out,
            r_out, mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable, lo_enable,
            hi_enable, r_in, con_enable, read, ram_write, pc_increment, gra, grb, grc, alu_op};
  endfunction

  task automatic test_reset();
    clr = 1'b1; ir = 32'h0; stop = 1'b0; con_ff = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs() !== 30'h0) begin
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, outs(), 30'h0); n_fail++;
      end
    end
    clr = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 30'h0) begin $display("FAIL reset_rst: got %h expected %h", outs(), 30'h0); n_fail++; end
  endtask

  task automatic test_ldi_ori();
    logic [31:0] code [2] = '{32'h0900_0015, 32'h7190_0053};
    logic [29:0] want [2][6] = '{
      '{F0, F1, F2, M_RUN | M_GRB | M_BAOUT | M_YEN, M_RUN | M_CSE | M_ZEN, WB},
      '{F0, F1, F2, M_RUN | M_GRB | M_ROUT | M_YEN, M_RUN | M_CSE | M_ZEN | 30'd3, WB}};
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        n_checks++;
        if (outs() !== want[j][i]) begin
          $display("FAIL ldi_ori instr %0d T%0d: got %h expected %h", j, i, outs(), want[j][i]); n_fail++;
        end
        if (i == 0) ir = code[j];
      end
  endtask

  task automatic test_alu();
    logic [31:0] code [6] = '{32'h1800_0000, 32'h2000_0000, 32'h2800_0000, 32'h3000_0000,
                              32'h6000_0000, 32'h6800_0000};
    logic [29:0] t4 [6] = '{
      M_RUN | M_GRC | M_ROUT | M_ZEN | 30'd0, M_RUN | M_GRC | M_ROUT | M_ZEN | 30'd1,
      M_RUN | M_GRC | M_ROUT | M_ZEN | 30'd2, M_RUN | M_GRC | M_ROUT | M_ZEN | 30'd3,
      M_RUN | M_CSE | M_ZEN | 30'd0,          M_RUN | M_CSE | M_ZEN | 30'd2};
    logic [29:0] want [6];
    for (int j = 0; j < 6; j++) begin
      want = '{F0, F1, F2, M_RUN | M_GRB | M_ROUT | M_YEN, t4[j], WB};
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        n_checks++;
        if (outs() !== want[i]) begin
          $display("FAIL alu ir=%h T%0d: got %h expected %h", code[j], i, outs(), want[i]); n_fail++;
        end
        if (i == 0) ir = code[j];
      end
    end
  endtask

  task automatic test_ld_st();
    logic [31:0] code [2] = '{32'h0000_0000, 32'h1000_0000};
    logic [29:0] want [2][8] = '{
      '{F0, F1, F2, M_RUN | M_GRB | M_BAOUT | M_YEN, M_RUN | M_CSE | M_ZEN, M_RUN | M_ZLOOUT | M_MAREN,
        M_RUN | M_READ | M_MDREN, M_RUN | M_MDROUT | M_GRA | M_RIN},
      '{F0, F1, F2, M_RUN | M_GRB | M_BAOUT | M_YEN, M_RUN | M_CSE | M_ZEN, M_RUN | M_ZLOOUT | M_MAREN,
        M_RUN | M_GRA | M_ROUT | M_MDREN, M_RUN | M_RAMW}};
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        n_checks++;
        if (outs() !== want[j][i]) begin
          $display("FAIL ld_st instr %0d T%0d: got %h expected %h", j, i, outs(), want[j][i]); n_fail++;
        end
        if (i == 0) ir = code[j];
      end
  endtask

  task automatic test_branch();
    logic [29:0] want [2][7] = '{
      '{F0, F1, F2, M_RUN | M_GRA | M_ROUT | M_CONEN, M_RUN | M_PCOUT | M_YEN, M_RUN | M_CSE | M_ZEN,
        M_RUN | M_ZLOOUT | M_PCEN},
      '{F0, F1, F2, M_RUN | M_GRA | M_ROUT | M_CONEN, M_RUN | M_PCOUT | M_YEN, M_RUN | M_CSE | M_ZEN,
        M_RUN}};
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        n_checks++;
        if (outs() !== want[j][i]) begin
          $display("FAIL branch con_ff=%0b T%0d: got %h expected %h", con_ff, i, outs(), want[j][i]); n_fail++;
        end
        if (i == 0) begin ir = 32'h9000_0004; con_ff = (j == 0); end
      end
    con_ff = 1'b0;
  endtask

  task automatic test_nop();
    logic [31:0] code [2] = '{32'hD000_0000, 32'hF800_0000};
    logic [29:0] want [4] = '{F0, F1, F2, M_RUN};
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        n_checks++;
        if (outs() !== want[i]) begin
          $display("FAIL nop ir=%h T%0d: got %h expected %h", code[j], i, outs(), want[i]); n_fail++;
        end
        if (i == 0) ir = code[j];
      end
  endtask

  task automatic test_stop();
    logic [29:0] want [6] = '{F0, F1, F2, M_RUN | M_GRB | M_ROUT | M_YEN, M_RUN | M_CSE | M_ZEN | 30'd3, WB};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs() !== want[i]) begin
        $display("FAIL stop_ori T%0d: got %h expected %h", i, outs(), want[i]); n_fail++;
      end
      if (i == 0) ir = 32'h7190_0053;
    end
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stop = 1'b0;
      n_checks++;
      if (outs() !== 30'h0) begin $display("FAIL stop_halt cycle %0d: got %h expected %h", i, outs(), 30'h0); n_fail++; end
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 30'h0) begin $display("FAIL stop_recover_rst: got %h expected %h", outs(), 30'h0); n_fail++; end
  endtask

  task automatic test_halt();
    logic [29:0] want [4] = '{F0, F1, F2, M_RUN};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs() !== want[i]) begin $display("FAIL halt_instr T%0d: got %h expected %h", i, outs(), want[i]); n_fail++; end
      if (i == 0) ir = 32'hD800_0000;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stop = i[0];
      n_checks++;
      if (outs() !== 30'h0) begin $display("FAIL halt_stay cycle %0d: got %h expected %h", i, outs(), 30'h0); n_fail++; end
    end
    stop = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 30'h0) begin $display("FAIL halt_recover_rst: got %h expected %h", outs(), 30'h0); n_fail++; end
  endtask

  task automatic test_clr_mid_st();
    logic [29:0] want [7] = '{F0, F1, F2, M_RUN | M_GRB | M_BAOUT | M_YEN, M_RUN | M_CSE | M_ZEN,
                              M_RUN | M_ZLOOUT | M_MAREN, M_RUN | M_GRA | M_ROUT | M_MDREN};
    logic [29:0] after [4] = '{F0, F1, F2, M_RUN};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs() !== want[i]) begin $display("FAIL clr_st T%0d: got %h expected %h", i, outs(), want[i]); n_fail++; end
      if (i == 0) ir = 32'h1000_0000;
    end
    clr = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 30'h0) begin $display("FAIL clr_async: got %h expected %h", outs(), 30'h0); n_fail++; end
    @(negedge clk);
    n_checks++;
    if (ram_write !== 1'b0 || outs() !== 30'h0) begin
      $display("FAIL clr_no_write: got %h expected %h", outs(), 30'h0); n_fail++;
    end
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs() !== after[i]) begin $display("FAIL clr_restart T%0d: got %h expected %h", i, outs(), after[i]); n_fail++; end
      if (i == 0) ir = 32'hD000_0000;
    end
  endtask

  initial begin
    test_reset();
    test_ldi_ori();
    test_alu();
    test_ld_st();
    test_branch();
    test_nop();
    test_stop();
    test_halt();
    test_clr_mid_st();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired multi-cycle control sequencer that drives every control input of Datapath; sits directly upstream of it and replaces bench-driven control sequencing.
- Runs the fetch cycles T0–T2, decodes the instruction register, then steps the per-opcode execute cycles.
- Produces exactly one control-step per clock (Moore outputs from state plus IR).

Parameters:
OP_W, 5, opcode field width (ir[31:27])
ALU_W, 4, width of alu_op select

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-high reset
ir  input  32  instruction register contents from Datapath
con_ff  input  1  branch condition flag from Datapath
stop  input  1  request halt at the next instruction boundary
run  output  1  1 while sequencing, 0 in RST/HALT
pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, c_sign_extended_out, ba_out, r_out  output  1 each  bus-drive selects
mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable, lo_enable, hi_enable, r_in, con_enable  output  1 each  register load enables
read, ram_write, pc_increment, gra, grb, grc  output  1 each  memory/ALU/register-select strobes
alu_op  output  ALU_W  ADD=0, SUB=1, AND=2, OR=3

Behaviour:
- Interface: one clock domain (clk). Reset clr is asynchronous and active-high. While clr=1: state=RST; all outputs 0, including alu_op=0 and run=0. First rising edge after release: RST->T0.
- Outputs are a combinational decode of state register and ir. Every control signal not listed for a state is 0. alu_op defaults to ADD.
- Opcodes (ir[31:27]) that are not listed below, including nop 11010, are treated as nop.
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, br 10010, nop 11010, halt 11011.
- Fetch, all opcodes:
  - T0: pc_out, mar_enable, pc_increment, z_enable.
  - T1: zlo_out, pc_enable, read, mdr_enable.
  - T2: mdr_out, ir_enable.
- Execute, ldi:
  - T3: grb, ba_out, y_enable.
  - T4: c_sign_extended_out, z_enable (ADD).
  - T5: zlo_out, gra, r_in.
- Execute, addi/andi/ori:
  - T3: grb, r_out, y_enable.
  - T4: c_sign_extended_out, z_enable, alu_op = ADD/AND/OR respectively.
  - T5: zlo_out, gra, r_in.
- Execute, add/sub/and/or:
  - T3: grb, r_out, y_enable.
  - T4: grc, r_out, z_enable, alu_op per opcode.
  - T5: zlo_out, gra, r_in.
- Execute, ld:
  - T3–T4 as ldi.
  - T5: zlo_out, mar_enable.
  - T6: read, mdr_enable.
  - T7: mdr_out, gra, r_in.
- Execute, st:
  - T3–T5 as ld.
  - T6: gra, r_out, mdr_enable (read=0).
  - T7: ram_write.
- Execute, br:
  - T3: gra, r_out, con_enable.
  - T4: pc_out, y_enable.
  - T5: c_sign_extended_out, z_enable (ADD).
  - T6: if con_ff=1 then zlo_out, pc_enable; else no signals. con_ff is sampled during T6 only.
- nop: T3 asserts nothing.
- halt: T3 asserts nothing; next state is HALT.
- Instruction length in cycles: ALU/immediate 6, ld/st 8, br 7, nop 4, halt 4 then HALT.
- Last execute step: next state is T0, or HALT if stop=1 at that clock edge. stop is ignored in all other states.
- HALT: all outputs 0, run=0. Left only via clr.
- Opcode is decoded from ir in T3 onward; ir is stable from the end of T2.
- clr asserted mid-instruction: immediate return to RST with outputs 0. No partial step completes; no ram_write is issued after clr rises.
- lo_enable, hi_enable, zhi_out, hi_out, lo_out are driven 0 in all states (reserved for mul/div/mfhi/mflo).

Test Plan:
- Reset/fetch: hold clr 2 cycles, release with ir=0 -> outputs all 0 in RST. Next three cycles show the T0/T1/T2 patterns exactly; run=1 from T0.
- ldi then ori: ir=0x09000015 (ldi r2,0x15(r0)) -> T3 grb+ba_out+y_enable, T5 zlo_out+gra+r_in. Then ir=0x71900053 (ori r3,r2,0x53) -> T4 alu_op=3 with c_sign_extended_out; next T0 on the 7th edge.
- add/sub: ir=0x18000000 -> T4 grc+r_out, alu_op=0. ir=0x20000000 -> alu_op=1. Each instruction is 6 cycles.
- ld/st: ir=0x00000000 -> T6 read+mdr_enable, T7 mdr_out+r_in. ir=0x10000000 -> T6 gra+r_out+mdr_enable with read=0, T7 ram_write=1 for exactly one cycle.
- Branch: ir=0x90000004 with con_ff=1 -> T6 zlo_out+pc_enable. Repeat with con_ff=0 -> T6 all 0. Both return to T0 after 7 cycles.
- Halt/stop/reset: ir=0xD8000000 -> HALT after T3, run=0, stays halted for 10 cycles. stop=1 during ori T5 -> HALT instead of T0. clr pulsed during st T6 -> ram_write never asserts and state returns to RST.
